evo_scheduler: RTL

- Generation-level controller for the cell evolution engine. It launches one full-board evolution pass per generation by toggling the engine's `global_evo_en` level, and detects pass completion by counting the engine's write strobes.
- It flips the double-buffered cell-RAM bank after each pass and paces free-running generations with a programmable period.
- It also executes a board-clear sweep of both RAM banks.
- It sits between the user-command decoder (keys/switches) and the evolution engine plus cell RAM address mux.

---
 rtl/game_pkg.sv | 19 +
 rtl/gen_period_timer.sv | 39 +++
 rtl/evo_scheduler.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the cell evolution engine: scheduler states,
// board size helper and watchdog multiplier.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EVOLVE = 3'd1,
    SWAP   = 3'd2,
    WAIT   = 3'd3,
    CLEAR  = 3'd4
  } sched_state_t;

  localparam int WD_MULT = 16;

  function automatic int cells(input int m, input int n);
    return m * n;
  endfunction

endpackage

// File: rtl/gen_period_timer.sv
// Loadable down-counter with a zero flag; paces the idle gap between
// free-running generations.
module gen_period_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  // Next count: load wins over decrement, decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != {W{1'b0}})) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == {W{1'b0}});

endmodule

// File: rtl/evo_scheduler.sv
// Generation-level controller: launches passes, flips the cell bank, paces
// free-run and sweeps a board clear. Optional watchdog: EVO_WATCHDOG_EN.
module evo_scheduler
  import game_pkg::*;
#(
  parameter int P_PARAM_M = 5,
  parameter int P_PARAM_N = 5,
  parameter int WIDTH     = 12,
  parameter int PERIOD_W  = 24,
  parameter int GEN_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_run,
  input  logic                  cmd_pause,
  input  logic                  cmd_step,
  input  logic                  cmd_clear,
  input  logic [PERIOD_W-1:0]   period,
  input  logic                  evo_wden,
  output logic                  evo_toggle,
  output logic                  bank_sel,
  output logic                  clr_wden,
  output logic [2*WIDTH-1:0]    clr_addr,
  output logic                  running,
  output logic                  busy,
  output logic [GEN_W-1:0]      gen_count,
  output logic                  err
);

  localparam int AW = 2 * WIDTH;
  localparam int CELLS = cells(P_PARAM_M, P_PARAM_N);
  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);

  sched_state_t state_q, state_d;
  logic toggle_q, toggle_d;
  logic bank_q, bank_d;
  logic clr_wden_q, clr_wden_d;
  logic running_q, running_d;
  logic busy_q, busy_d;
  logic pend_q, pend_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [GEN_W-1:0] gen_q, gen_d;

  logic tmr_load_s, tmr_dec_s, tmr_zero_s;
  logic [PERIOD_W-1:0] tmr_val_s;
  logic swap_pend_s, swap_run_s;

`ifdef EVO_WATCHDOG_EN
  localparam int WD_LIMIT = WD_MULT * CELLS;
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic err_q, err_d;
`endif

  // A period of 0 behaves like 1: the timer always holds at least one WAIT cycle.
  assign tmr_val_s = (period == {PERIOD_W{1'b0}}) ? {PERIOD_W{1'b0}}
                                                  : (period - PERIOD_W'(1));

  gen_period_timer #(.W(PERIOD_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .dec      (tmr_dec_s),
    .zero     (tmr_zero_s)
  );

  // Next-state and next-output logic for the generation sequencer.
  always_comb begin
    state_d     = state_q;
    toggle_d    = toggle_q;
    bank_d      = bank_q;
    clr_wden_d  = clr_wden_q;
    clr_addr_d  = clr_addr_q;
    running_d   = running_q;
    pend_d      = pend_q;
    wr_cnt_d    = wr_cnt_q;
    gen_d       = gen_q;
    tmr_load_s  = 1'b0;
    tmr_dec_s   = 1'b0;
    swap_pend_s = pend_q | cmd_clear;
    swap_run_s  = cmd_pause ? 1'b0 : (cmd_run ? 1'b1 : running_q);
`ifdef EVO_WATCHDOG_EN
    wd_d  = wd_q;
    err_d = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_clear) begin
          state_d    = CLEAR;
          clr_wden_d = 1'b1;
          clr_addr_d = {AW{1'b0}};
        end else if (cmd_pause) begin
          running_d = 1'b0;
        end else if (cmd_step || cmd_run) begin
          running_d = cmd_step ? running_q : 1'b1;
          toggle_d  = ~toggle_q;
          wr_cnt_d  = {AW{1'b0}};
          state_d   = EVOLVE;
`ifdef EVO_WATCHDOG_EN
          wd_d = {WD_W{1'b0}};
`endif
        end else begin
          state_d = IDLE;
        end
      end
      EVOLVE: begin
        if (cmd_clear) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        if (cmd_pause) begin
          running_d = 1'b0;
        end else if (cmd_run) begin
          running_d = 1'b1;
        end else begin
          running_d = running_q;
        end
        if (evo_wden) begin
          wr_cnt_d = wr_cnt_q + AW'(1);
          if (wr_cnt_q == LAST_CELL) begin
            state_d = SWAP;
          end else begin
            state_d = EVOLVE;
          end
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
`ifdef EVO_WATCHDOG_EN
        wd_d = wd_q + WD_W'(1);
        if (!(evo_wden && (wr_cnt_q == LAST_CELL)) && (wd_q == WD_LAST)) begin
          err_d     = 1'b1;
          running_d = 1'b0;
          pend_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          err_d = err_q;
        end
`endif
      end
      SWAP: begin
        bank_d    = ~bank_q;
        gen_d     = gen_q + GEN_W'(1);
        running_d = swap_run_s;
        pend_d    = swap_pend_s;
        if (swap_pend_s) begin
          state_d    = CLEAR;
          clr_wden_d = 1'b1;
          clr_addr_d = {AW{1'b0}};
        end else if (swap_run_s) begin
          state_d    = WAIT;
          tmr_load_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cmd_clear) begin
          state_d    = CLEAR;
          clr_wden_d = 1'b1;
          clr_addr_d = {AW{1'b0}};
        end else if (cmd_pause) begin
          running_d = 1'b0;
          state_d   = IDLE;
        end else if (tmr_zero_s) begin
          toggle_d = ~toggle_q;
          wr_cnt_d = {AW{1'b0}};
          state_d  = EVOLVE;
`ifdef EVO_WATCHDOG_EN
          wd_d = {WD_W{1'b0}};
`endif
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_addr_q == LAST_CELL) begin
          clr_wden_d = 1'b0;
          clr_addr_d = {AW{1'b0}};
          bank_d     = 1'b0;
          gen_d      = {GEN_W{1'b0}};
          running_d  = 1'b0;
          pend_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef EVO_WATCHDOG_EN
    // Any accepted clear also releases a latched watchdog error.
    if ((state_d == CLEAR) && (state_q != CLEAR)) begin
      err_d = 1'b0;
    end else begin
      err_d = err_d;
    end
`endif
    busy_d = (state_d == EVOLVE) || (state_d == SWAP) || (state_d == CLEAR);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      toggle_q   <= 1'b0;
      bank_q     <= 1'b0;
      clr_wden_q <= 1'b0;
      clr_addr_q <= {AW{1'b0}};
      running_q  <= 1'b0;
      busy_q     <= 1'b0;
      pend_q     <= 1'b0;
      wr_cnt_q   <= {AW{1'b0}};
      gen_q      <= {GEN_W{1'b0}};
`ifdef EVO_WATCHDOG_EN
      wd_q       <= {WD_W{1'b0}};
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      toggle_q   <= toggle_d;
      bank_q     <= bank_d;
      clr_wden_q <= clr_wden_d;
      clr_addr_q <= clr_addr_d;
      running_q  <= running_d;
      busy_q     <= busy_d;
      pend_q     <= pend_d;
      wr_cnt_q   <= wr_cnt_d;
      gen_q      <= gen_d;
`ifdef EVO_WATCHDOG_EN
      wd_q       <= wd_d;
      err_q      <= err_d;
`endif
    end
  end

  assign evo_toggle = toggle_q;
  assign bank_sel   = bank_q;
  assign clr_wden   = clr_wden_q;
  assign clr_addr   = clr_addr_q;
  assign running    = running_q;
  assign busy       = busy_q;
  assign gen_count  = gen_q;
`ifdef EVO_WATCHDOG_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
